// File: rtl/osd_rect_overlay.sv
// Rectangular border overlay on a pixel stream, with frame-synchronous config update and optional blink.
// Latency: exactly 1 clk from i_hs/i_vs/i_de/i_data/x/y to o_hs/o_vs/o_de/o_data; all outputs registered.
// Backpressure: none; a free-running video stream that must be accepted every cycle.
module osd_rect_overlay #(
    parameter int DATA_WIDTH = 16,
    parameter int BLINK_BIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [11:0]           x,
    input  logic [11:0]           y,
    input  logic                  cfg_valid,
    input  logic                  cfg_en,
    input  logic                  cfg_blink,
    input  logic [11:0]           cfg_x0,
    input  logic [11:0]           cfg_y0,
    input  logic [11:0]           cfg_x1,
    input  logic [11:0]           cfg_y1,
    input  logic [3:0]            cfg_thick,
    input  logic [DATA_WIDTH-1:0] cfg_color,
    output logic                  cfg_pending,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [7:0]            frame_cnt
);

    // One configuration bank; both the pending and the active bank use this layout.
    typedef struct packed {
        logic                  en;
        logic                  blink;
        logic [11:0]           x0;
        logic [11:0]           y0;
        logic [11:0]           x1;
        logic [11:0]           y1;
        logic [3:0]            thick;
        logic [DATA_WIDTH-1:0] color;
    } cfg_bank_t;

    cfg_bank_t             r_pend_bank;
    cfg_bank_t             r_act_bank;
    logic                  r_cfg_pending;
    logic                  r_vs_d;
    logic [7:0]            r_frame_cnt;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_de;
    logic [DATA_WIDTH-1:0] r_data;

    cfg_bank_t             w_cfg_in;
    logic                  w_boundary;
    logic [3:0]            w_t;
    logic                  w_inside;
    logic [11:0]           w_dx0;
    logic [11:0]           w_dx1;
    logic [11:0]           w_dy0;
    logic [11:0]           w_dy1;
    logic                  w_border;
    logic                  w_blink_ok;
    logic                  w_show;

    assign w_cfg_in = '{en:    cfg_en,
                        blink: cfg_blink,
                        x0:    cfg_x0,
                        y0:    cfg_y0,
                        x1:    cfg_x1,
                        y1:    cfg_y1,
                        thick: cfg_thick,
                        color: cfg_color};

    // A frame starts on the 0->1 edge of i_vs only; a held-high i_vs does not retrigger.
    assign w_boundary = i_vs & ~r_vs_d;

    // Frame-edge detector and frame counter (wraps naturally at 8 bits).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d      <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_vs_d <= i_vs;
            if (w_boundary) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Double-buffered config: writes land in pending and are promoted only at a frame boundary,
    // except a write that coincides with the boundary, which goes straight to active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_bank   <= '0;
            r_act_bank    <= '0;
            r_cfg_pending <= 1'b0;
        end else begin
            if (cfg_valid) begin
                r_pend_bank <= w_cfg_in;
            end
            if (w_boundary) begin
                if (cfg_valid) begin
                    r_act_bank <= w_cfg_in;
                end else if (r_cfg_pending) begin
                    r_act_bank <= r_pend_bank;
                end
                r_cfg_pending <= 1'b0;
            end else if (cfg_valid) begin
                r_cfg_pending <= 1'b1;
            end
        end
    end

    // Hit test against the active bank. The offsets are only meaningful when inside,
    // where every subtraction is known to be non-negative, so 12-bit wrap cannot occur.
    always_comb begin
        w_t        = (r_act_bank.thick == 4'd0) ? 4'd1 : r_act_bank.thick;
        w_inside   = (x >= r_act_bank.x0) && (x <= r_act_bank.x1) &&
                     (y >= r_act_bank.y0) && (y <= r_act_bank.y1);
        w_dx0      = x - r_act_bank.x0;
        w_dx1      = r_act_bank.x1 - x;
        w_dy0      = y - r_act_bank.y0;
        w_dy1      = r_act_bank.y1 - y;
        w_border   = w_inside && ((w_dx0 < {8'd0, w_t}) || (w_dx1 < {8'd0, w_t}) ||
                                  (w_dy0 < {8'd0, w_t}) || (w_dy1 < {8'd0, w_t}));
        w_blink_ok = ~r_act_bank.blink | ~r_frame_cnt[BLINK_BIT];
        w_show     = r_act_bank.en & w_border & i_de & w_blink_ok;
    end

    // Output stage: syncs delayed by one clock, pixel replaced by border colour when shown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_de   <= 1'b0;
            r_data <= '0;
        end else begin
            r_hs   <= i_hs;
            r_vs   <= i_vs;
            r_de   <= i_de;
            r_data <= w_show ? r_act_bank.color : i_data;
        end
    end

    assign o_hs        = r_hs;
    assign o_vs        = r_vs;
    assign o_de        = r_de;
    assign o_data      = r_data;
    assign cfg_pending = r_cfg_pending;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_osd_rect_overlay.sv
// Directed bench for osd_rect_overlay with a scoreboard of expected output beats.
// Latency: expects every output one clk after its input beat.
// Backpressure: none; stream driven every cycle.
module tb_osd_rect_overlay;
    localparam int DW = 16;
    localparam int BB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [11:0]   x = '0, y = '0;
    logic          cfg_valid = 1'b0, cfg_en = 1'b0, cfg_blink = 1'b0;
    logic [11:0]   cfg_x0 = '0, cfg_y0 = '0, cfg_x1 = '0, cfg_y1 = '0;
    logic [3:0]    cfg_thick = '0;
    logic [DW-1:0] cfg_color = '0;
    logic          cfg_pending, o_hs, o_vs, o_de;
    logic [DW-1:0] o_data;
    logic [7:0]    frame_cnt;

    osd_rect_overlay #(.DATA_WIDTH(DW), .BLINK_BIT(BB)) dut (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .x(x), .y(y), .cfg_valid(cfg_valid), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
        .cfg_thick(cfg_thick), .cfg_color(cfg_color), .cfg_pending(cfg_pending),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data), .frame_cnt(frame_cnt));

    typedef struct packed {
        logic hs, vs, de;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic en, blink;
        logic [11:0] x0, y0, x1, y1;
        logic [3:0] thick;
        logic [DW-1:0] color;
    } cfg_t;

    beat_t      sb[$];
    cfg_t       m_act = '0, m_stg = '0;
    logic       m_pend = 1'b0, m_pvs = 1'b0;
    logic [7:0] m_fc = 8'd0;
    int         n_tests = 0, n_fail = 0;
    int         gx[$], gy[$];
    logic [DW-1:0] last_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Border = inside the outer box but not inside the box shrunk by t on every side.
    function automatic bit hit(input cfg_t c, input int xx, input int yy);
        int x0 = int'(c.x0), x1 = int'(c.x1), y0 = int'(c.y0), y1 = int'(c.y1);
        int t  = (c.thick == 4'd0) ? 1 : int'(c.thick);
        bit outer = (xx >= x0) && (xx <= x1) && (yy >= y0) && (yy <= y1);
        bit inner = (xx >= x0 + t) && (xx <= x1 - t) && (yy >= y0 + t) && (yy <= y1 - t);
        return outer && !inner;
    endfunction

    // One stream beat: drive at negedge, push expectation, compare #1 after the posedge.
    task automatic tick(input logic wr, input logic hs, input logic vs, input logic de,
                        input logic [11:0] xx, input logic [11:0] yy, input logic [DW-1:0] d);
        beat_t e;
        cfg_t  cin;
        logic  bnd;
        @(negedge clk);
        cfg_valid = wr; i_hs = hs; i_vs = vs; i_de = de; x = xx; y = yy; i_data = d;
        last_d = d;
        cin = {cfg_en, cfg_blink, cfg_x0, cfg_y0, cfg_x1, cfg_y1, cfg_thick, cfg_color};
        if (!rst_n) begin
            e = '0;
        end else begin
            e.hs = hs; e.vs = vs; e.de = de;
            e.data = (de && m_act.en && hit(m_act, int'(xx), int'(yy)) &&
                      !(m_act.blink && m_fc[BB])) ? m_act.color : d;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_act = '0; m_stg = '0; m_pend = 1'b0; m_pvs = 1'b0; m_fc = 8'd0;
        end else begin
            bnd   = vs && !m_pvs;
            m_pvs = vs;
            if (wr) m_stg = cin;
            if (bnd) begin
                m_fc = m_fc + 8'd1;
                if (wr) m_act = cin;
                else if (m_pend) m_act = m_stg;
                m_pend = 1'b0;
            end else if (wr) begin
                m_pend = 1'b1;
            end
        end
        e = sb.pop_front();
        chk("o_hs", 32'(o_hs), 32'(e.hs));
        chk("o_vs", 32'(o_vs), 32'(e.vs));
        chk("o_de", 32'(o_de), 32'(e.de));
        chk("o_data", 32'(o_data), 32'(e.data));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        cfg_valid = 1'b0;
    endtask

    task automatic px(input int xx, input int yy);
        tick(1'b0, xx == 0, 1'b0, 1'b1, 12'(xx), 12'(yy), DW'($urandom));
    endtask

    task automatic wr_px(input int xx, input int yy);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 12'(xx), 12'(yy), DW'($urandom));
    endtask

    task automatic vsync();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, DW'($urandom));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, DW'($urandom));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, DW'($urandom));
    endtask

    task automatic probe();
        foreach (gy[j]) foreach (gx[i]) px(gx[i], gy[j]);
    endtask

    task automatic set_cfg(input logic en, input logic bl, input int x0, input int y0,
                           input int x1, input int y1, input int th, input logic [DW-1:0] col);
        cfg_en = en; cfg_blink = bl; cfg_x0 = 12'(x0); cfg_y0 = 12'(y0);
        cfg_x1 = 12'(x1); cfg_y1 = 12'(y1); cfg_thick = 4'(th); cfg_color = col;
    endtask

    initial begin
        logic [7:0] fc_save;
        // Reset state
        tick(1'b0, 1'b1, 1'b1, 1'b1, 12'd5, 12'd5, 16'hABCD);
        chk("reset_o_data", 32'(o_data), 32'h0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'h0);
        rst_n = 1'b1;

        // Basic box, written mid-frame: deferred to next frame
        vsync();
        px(0, 0); px(1, 0);
        set_cfg(1'b1, 1'b0, 100, 50, 199, 149, 2, 16'hF800);
        wr_px(2, 0);
        chk("pending_after_write", 32'(cfg_pending), 32'h1);
        gx = '{0, 99, 100, 101, 102, 150, 197, 198, 199, 200, 639};
        gy = '{0, 49, 50, 51, 52, 100, 147, 148, 149, 150, 479};
        probe();
        chk("pending_held", 32'(cfg_pending), 32'h1);
        vsync();
        chk("pending_cleared", 32'(cfg_pending), 32'h0);
        probe();
        px(100, 50);
        chk("corner_color", 32'(o_data), 32'hF800);
        px(199, 149);
        chk("far_corner_color", 32'(o_data), 32'hF800);
        px(150, 100);
        chk("interior_passthru", 32'(o_data), 32'(last_d));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 12'd100, 12'd50, 16'h5A5A);
        chk("blank_passthru", 32'(o_data), 32'h5A5A);

        // Overwrite: two writes in one frame, the latest wins
        set_cfg(1'b1, 1'b0, 100, 50, 199, 149, 2, 16'h001F);
        wr_px(10, 10);
        px(100, 50);
        set_cfg(1'b1, 1'b0, 100, 50, 199, 149, 2, 16'h07E0);
        wr_px(11, 10);
        vsync();
        px(198, 60);
        chk("overwrite_latest", 32'(o_data), 32'h07E0);

        // Coincident write on the i_vs rise, with i_vs then held high
        set_cfg(1'b1, 1'b0, 100, 50, 199, 149, 2, 16'h1234);
        fc_save = frame_cnt;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 16'h0);
        chk("coincident_no_pending", 32'(cfg_pending), 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 16'h0);
        chk("vs_held_no_retrigger", 32'(frame_cnt), 32'(fc_save + 8'd1));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'h0);
        px(100, 50);
        chk("coincident_applied", 32'(o_data), 32'h1234);

        // Empty box: x0 > x1
        set_cfg(1'b1, 1'b0, 300, 50, 200, 149, 2, 16'hFFFF);
        wr_px(0, 0);
        vsync();
        gx = '{199, 200, 201, 250, 299, 300, 301};
        gy = '{49, 50, 100, 149};
        probe();
        px(250, 50);
        chk("empty_box_passthru", 32'(o_data), 32'(last_d));

        // thick=0 acts as a 1-pixel border
        set_cfg(1'b1, 1'b0, 10, 10, 20, 20, 0, 16'hAAAA);
        wr_px(0, 0);
        vsync();
        gx = '{9, 10, 11, 15, 19, 20, 21};
        gy = '{9, 10, 11, 15, 19, 20, 21};
        probe();
        px(10, 15);
        chk("thick0_edge", 32'(o_data), 32'hAAAA);
        px(11, 11);
        chk("thick0_inner", 32'(o_data), 32'(last_d));

        // Full-screen box with thick=15
        set_cfg(1'b1, 1'b0, 0, 0, 639, 479, 15, 16'h5555);
        wr_px(0, 0);
        vsync();
        gx = '{0, 1, 14, 15, 16, 320, 623, 624, 625, 638, 639};
        gy = '{0, 14, 15, 200, 464, 465, 479};
        probe();
        px(639, 479);
        chk("full_far_corner", 32'(o_data), 32'h5555);
        px(15, 15);
        chk("full_inner", 32'(o_data), 32'(last_d));

        // Blink over 64 frames
        set_cfg(1'b1, 1'b1, 100, 50, 199, 149, 2, 16'hF800);
        wr_px(0, 0);
        for (int f = 0; f < 64; f++) begin
            vsync();
            px(100, 50);
            chk("blink_gate", 32'(o_data), frame_cnt[BB] ? 32'(last_d) : 32'hF800);
            px(150, 100);
        end

        // Frame counter wraps 255 -> 0
        for (int f = 0; f < 300 && frame_cnt != 8'd255; f++) vsync();
        chk("fc_at_255", 32'(frame_cnt), 32'd255);
        vsync();
        chk("fc_wrapped", 32'(frame_cnt), 32'd0);

        // Reset for one clock mid-line
        set_cfg(1'b1, 1'b0, 100, 50, 199, 149, 2, 16'hF800);
        wr_px(0, 0);
        vsync();
        px(100, 50); px(101, 50);
        rst_n = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b1, 12'd102, 12'd50, 16'h7777);
        chk("rst_o_data", 32'(o_data), 32'h0);
        chk("rst_o_hs", 32'(o_hs), 32'h0);
        chk("rst_fc", 32'(frame_cnt), 32'h0);
        rst_n = 1'b1;
        vsync();
        chk("fc_first_after_rst", 32'(frame_cnt), 32'd1);
        px(100, 50);
        chk("disabled_after_rst", 32'(o_data), 32'(last_d));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/osd_rect_overlay.md
# osd_rect_overlay

Overlays a configurable rectangular border on the video stream after the x/y position stage. It feeds the VGA output or the next overlay stage. Configuration is written at any time but takes effect only at a frame boundary, so a box never tears mid-frame. An optional frame-counter-driven blink is provided.

## Interface
- DATA_WIDTH, 16, pixel width (RGB565 by default)
- BLINK_BIT, 4, bit of the frame counter that gates blinking (period = 2^(BLINK_BIT+1) frames)

- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_hs / i_vs / i_de  in  1 each  sync and data-enable, aligned with x/y
- i_data  in  DATA_WIDTH  pixel
- x, y  in  12 each  position of the current pixel (valid while i_de=1)
- cfg_valid  in  1  single-cycle write strobe for all cfg_* fields
- cfg_en  in  1  overlay enable
- cfg_blink  in  1  blink enable
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  12 each  inclusive box corners
- cfg_thick  in  4  border thickness in pixels (0 treated as 1)
- cfg_color  in  DATA_WIDTH  border colour
- cfg_pending  out  1  a written config is waiting for the next frame boundary
- o_hs / o_vs / o_de  out  1 each  delayed syncs
- o_data  out  DATA_WIDTH  output pixel
- frame_cnt  out  8  frames seen since reset

## Operation
- Frame boundary means rising edge of i_vs: i_vs=1 while the registered previous i_vs=0.
- Config has two register banks: pending and active.
  - cfg_valid copies all cfg_* into pending and sets cfg_pending.
  - On a frame boundary with cfg_pending=1, pending is copied to active and cfg_pending clears.
  - If cfg_valid occurs while cfg_pending=1, pending is overwritten. The latest write wins.
  - If cfg_valid coincides with a frame boundary, the new cfg_* values go straight to active and cfg_pending stays 0.
- frame_cnt increments on every frame boundary and wraps 255→0.
- Hit test uses the active bank and the current x/y. Let t = max(cfg_thick, 1).
  - inside = x0≤x≤x1 and y0≤y≤y1.
  - border = inside and (x−x0<t or x1−x<t or y−y0<t or y1−y<t).
  - Subtractions are 12-bit unsigned, done only when inside, so they never underflow.
  - If x0>x1 or y0>y1, the box is empty and nothing is drawn.
- show = active en, and border, and i_de, and (not active blink, or frame_cnt[BLINK_BIT]=0).
- o_data = show ? active color : i_data. Blanking pixels are never modified.
- Reset values:
  - all outputs 0, frame_cnt 0, cfg_pending 0
  - active and pending banks all 0, so the overlay is disabled
  - the registered previous i_vs is 0

## Timing
- Latency is exactly 1 clk for o_hs, o_vs, o_de and o_data relative to i_hs, i_vs, i_de, i_data, x and y. All outputs are registered.
- Frame-boundary cycle:
  - The pixel presented on that cycle is evaluated with the old active bank and old frame_cnt.
  - The new bank and frame_cnt take effect from the next cycle.
- cfg_pending rises the cycle after cfg_valid. It falls the cycle after the applying frame boundary.
- Reset mid-frame: everything returns to reset values on the next clk edge. The first frame boundary after reset increments frame_cnt to 1.
- An i_vs that is held high does not retrigger; only the 0→1 transition counts.

## Test plan
- Basic box, 640x480 stream:
  - stimulus: cfg_valid once with en=1, box (100,50)-(199,149), thick=2, color=16'hF800, then two frames
  - required: pixels on rows 50–51 and 148–149 and columns 100–101 and 198–199 within the box equal F800; pixel (150,100) equals the input; no change in the first frame.
- Deferred update:
  - stimulus: write config mid-frame
  - required: cfg_pending=1 until the next i_vs rise; the current frame output equals the input stream bit-exactly.
- Overwrite and coincident write:
  - stimulus: two writes within one frame (color 001F, then 07E0)
  - required: only 07E0 is drawn.
  - stimulus: cfg_valid on the i_vs rise cycle
  - required: applied at once, cfg_pending stays 0.
- Degenerate boxes:
  - stimulus: x0=300, x1=200
  - required: no overlay pixels.
  - stimulus: thick=0
  - required: 1-pixel border.
  - stimulus: box (0,0)-(639,479) with thick=15
  - required: correct border at the image edges with no wrap artefacts.
- Blink with BLINK_BIT=4 over 64 frames:
  - required: border visible when frame_cnt[4]=0, hidden when it is 1.
  - required: frame_cnt wraps 255→0 after 256 frames.
- Latency and reset:
  - required: o_hs, o_vs and o_de equal the inputs delayed by 1 clk.
  - stimulus: rst_n=0 for one clk mid-line
  - required: all outputs 0 on the next cycle; overlay disabled until reconfigured.
